ledpanel_framebuf: RTL and testbench
====================================

// Module: ledpanel_framebuf
// PURPOSE
//  Double-buffered pixel frame buffer feeding the RGB LED panel scan driver (upstream stage).
//  CPU side writes pixels (x,y) into the back buffer; the driver reads upper/lower pixel pairs
//  (rgb1/rgb2) from the front buffer per row-pair/column. Buffers swap only at frame boundary.
//  Also provides a hardware clear of the back buffer.
// PARAMETERS
//  COLS       32  panel columns per row; X_W = clog2(COLS)
//  ROWS       16  panel rows; ROW_PAIRS = ROWS/2, Y_W = clog2(ROWS), R_W = clog2(ROW_PAIRS)
//  RGB_W      3   bits per pixel, one on/off bit each for R, G, B
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-low reset
//  wr_en       in   1      write pixel strobe; accepted only when wr_ready=1
//  wr_x        in   X_W    column
//  wr_y        in   Y_W    row; y < ROW_PAIRS -> upper bank (rgb1), else lower bank (rgb2)
//  wr_rgb      in   RGB_W  pixel value
//  wr_ready    out  1      0 while a clear runs
//  clear_req   in   1      pulse: zero the entire back buffer
//  swap_req    in   1      pulse: request front/back swap at next frame boundary
//  swap_done   out  1      1-cycle pulse when a swap executes
//  frame_done  in   1      pulse from driver after last row-pair latch
//  rd_req      in   1      driver read strobe
//  rd_row      in   R_W    row-pair index
//  rd_col      in   X_W    column
//  rd_valid    out  1      rd_req delayed 1 cycle
//  rd_rgb1     out  RGB_W  upper-half pixel of front buffer (registered)
//  rd_rgb2     out  RGB_W  lower-half pixel of front buffer (registered)
// BEHAVIOUR
//  Reset: wr_ready=1, swap_done=0, rd_valid=0, rd_rgb1/rd_rgb2=0, front=0, pending=0,
//   state=IDLE, clr_addr=0. RAM contents are not reset.
//  Storage: 2 buffers x 2 banks x (ROW_PAIRS*COLS) words of RGB_W bits. Bank addr = {row, col}.
//  Read: 1-cycle latency; data from buffer `front`. rd_rgb* holds its last value when rd_req=0.
//  Write: on wr_en && wr_ready, write buffer ~front, bank wr_y[Y_W-1], addr {wr_y[R_W-1:0], wr_x}.
//   wr_en with wr_ready=0 is dropped with no side effects.
//  FSM: IDLE -> CLEAR on clear_req. CLEAR writes 0 to both banks of the back buffer at clr_addr,
//   clr_addr++ each cycle; after ROW_PAIRS*COLS cycles (256 by default) -> IDLE, clr_addr=0.
//   clear_req while in CLEAR is ignored. wr_ready = (state==IDLE).
//  Swap: swap_req sets pending. Swap executes on a cycle with frame_done && (pending || swap_req)
//   && state==IDLE: front <= ~front, pending <= 0, swap_done = 1 next cycle.
//   swap_req and frame_done in the same cycle -> swap executes that cycle.
//   frame_done during CLEAR -> no swap; pending is held for the next frame_done.
//   Repeated swap_req while pending -> a single swap.
//   The swap takes effect for the first rd_req after the swap cycle.
//  Reset mid-clear: abort; the partially cleared buffer is left as is.
// CONFIGURATION
//  LEDPANEL_FB_READBACK_EN defined: adds ports rb_en (in,1), rb_valid (out,1) and rb_rgb (out,RGB_W).
//   rb_en reads the back buffer at (wr_x,wr_y) with 1-cycle latency. rb_rgb resets to 0.
//   rb_en during CLEAR returns 0 with rb_valid=1.
//  Not defined: the ports are absent and the back-buffer RAMs are write-only on the CPU side.
// STRUCTURE
//  ledpanel_pkg: COLS/ROWS defaults, derived widths, FSM encoding (FB_IDLE, FB_CLEAR).
//  Sub-module ledpanel_fb_bank: simple dual-port RAM (1 sync write, 1 sync read), instanced 4x.
//   The top level muxes by front/bank.
// TESTING
//  Write (x=5,y=2,rgb=3'b101) then swap_req+frame_done; rd_row=2,rd_col=5 -> rd_rgb1=3'b101 next cycle.
//  Write y=10,x=31,rgb=3'b011, swap; read row=2,col=31 -> rd_rgb2=3'b011, rd_rgb1 unchanged from prior data.
//  swap_req with no frame_done for 1000 cycles -> front unchanged, no swap_done;
//   then frame_done -> swap_done pulse one cycle later.
//  clear_req -> wr_ready=0 for exactly 256 cycles and wr_en is dropped;
//   after swap, all reads return 0.
//  frame_done during CLEAR with swap pending -> no swap;
//   next frame_done after clear ends -> swap executes.
//  Assert reset mid-clear (cycle 100) -> wr_ready=1, rd_valid=0, front=0 immediately
//   (asynchronous, without a clk edge).

Source files
------------

// File: rtl/ledpanel_pkg.sv
// Shared geometry, derived widths, pixel types and FSM encoding for the LED panel frame buffer.
package ledpanel_pkg;
    localparam int unsigned COLS      = 32;
    localparam int unsigned ROWS      = 16;
    localparam int unsigned RGB_W     = 3;
    localparam int unsigned ROW_PAIRS = ROWS / 2;
    localparam int unsigned X_W       = $clog2(COLS);
    localparam int unsigned Y_W       = $clog2(ROWS);
    localparam int unsigned R_W       = $clog2(ROW_PAIRS);
    localparam int unsigned A_W       = R_W + X_W;
    localparam int unsigned DEPTH     = ROW_PAIRS * COLS;

    typedef logic [RGB_W-1:0] rgb_t;

    // Upper/lower pixel pair as presented to the scan driver
    typedef struct packed {
        rgb_t rgb1;
        rgb_t rgb2;
    } rgb_pair_t;

    typedef enum logic [0:0] {
        FB_IDLE  = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_t;

    function automatic logic [A_W-1:0] bank_addr(input logic [R_W-1:0] row,
                                                 input logic [X_W-1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/ledpanel_framebuf_if.sv
// Pixel write, scan read and swap/clear control bundle for ledpanel_framebuf.
// Back-buffer readback signals exist only when LEDPANEL_FB_READBACK_EN is defined.
interface ledpanel_framebuf_if;
    import ledpanel_pkg::*;

    logic           wr_en;
    logic [X_W-1:0] wr_x;
    logic [Y_W-1:0] wr_y;
    rgb_t           wr_rgb;
    logic           wr_ready;
    logic           clear_req;
    logic           swap_req;
    logic           swap_done;
    logic           frame_done;
    logic           rd_req;
    logic [R_W-1:0] rd_row;
    logic [X_W-1:0] rd_col;
    logic           rd_valid;
    rgb_t           rd_rgb1;
    rgb_t           rd_rgb2;
`ifdef LEDPANEL_FB_READBACK_EN
    logic           rb_en;
    logic           rb_valid;
    rgb_t           rb_rgb;
`endif

    modport master (
`ifdef LEDPANEL_FB_READBACK_EN
        output rb_en,
        input  rb_valid, rb_rgb,
`endif
        output wr_en, wr_x, wr_y, wr_rgb, clear_req, swap_req, frame_done,
               rd_req, rd_row, rd_col,
        input  wr_ready, swap_done, rd_valid, rd_rgb1, rd_rgb2
    );

    modport slave (
`ifdef LEDPANEL_FB_READBACK_EN
        input  rb_en,
        output rb_valid, rb_rgb,
`endif
        input  wr_en, wr_x, wr_y, wr_rgb, clear_req, swap_req, frame_done,
               rd_req, rd_row, rd_col,
        output wr_ready, swap_done, rd_valid, rd_rgb1, rd_rgb2
    );
endinterface

// File: rtl/ledpanel_fb_bank.sv
// One half-panel pixel bank: simple dual-port RAM, one synchronous write and one synchronous read.
module ledpanel_fb_bank
    import ledpanel_pkg::*;
(
    input  logic           clk,
    input  logic           we,
    input  logic [A_W-1:0] waddr,
    input  rgb_t           wdata,
    input  logic           re,
    input  logic [A_W-1:0] raddr,
    output rgb_t           rdata
);
    rgb_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ledpanel_framebuf.sv
// Double-buffered LED panel frame buffer: CPU writes the back buffer, scan driver reads the front,
// swap only at frame boundary. LEDPANEL_FB_READBACK_EN adds a CPU readback port on the back buffer.
module ledpanel_framebuf
    import ledpanel_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    ledpanel_framebuf_if.slave bus
);
    fb_state_t      state_q, state_d;
    logic [A_W-1:0] clr_addr_q, clr_addr_d;
    logic           wr_ready_q, front_q, pending_q, swap_done_q;
    logic           rd_valid_q, rd_sel_q;
    rgb_pair_t      rd_hold_q, rd_mux;
    logic           clearing, wr_acc, do_swap, rb_req;
    logic [A_W-1:0] wr_addr, rd_addr;
    rgb_t           bank_rdata [2][2];

    assign clearing = (state_q == FB_CLEAR);
    assign wr_acc   = bus.wr_en && wr_ready_q;
    assign do_swap  = bus.frame_done && (pending_q || bus.swap_req) && (state_q == FB_IDLE);
    assign wr_addr  = bank_addr(bus.wr_y[R_W-1:0], bus.wr_x);
    assign rd_addr  = bank_addr(bus.rd_row, bus.rd_col);

    // Clear sequencer next state
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            FB_IDLE: begin
                if (bus.clear_req) state_d = FB_CLEAR;
            end
            FB_CLEAR: begin
                if (clr_addr_q == A_W'(DEPTH - 1)) begin
                    state_d    = FB_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + A_W'(1);
                end
            end
            default: state_d = FB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FB_IDLE;
            clr_addr_q <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_ready_q <= (state_d == FB_IDLE);
        end
    end

    // Swap control and scan-read pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            swap_done_q <= do_swap;
            if (do_swap) begin
                front_q   <= ~front_q;
                pending_q <= 1'b0;
            end else if (bus.swap_req) begin
                pending_q <= 1'b1;
            end
            rd_valid_q <= bus.rd_req;
            rd_sel_q   <= front_q;
            if (rd_valid_q) rd_hold_q <= rd_mux;
        end
    end

    // Front buffer banks serve the scan driver; back buffer banks take writes, clears and readback
    for (genvar b = 0; b < 2; b++) begin : g_buf
        for (genvar k = 0; k < 2; k++) begin : g_bank
            logic           is_back, we, re;
            logic [A_W-1:0] waddr, raddr;
            rgb_t           wdata;

            assign is_back = (front_q != 1'(b));
            assign we      = is_back && (clearing || (wr_acc && (bus.wr_y[Y_W-1] == 1'(k))));
            assign waddr   = clearing ? clr_addr_q : wr_addr;
            assign wdata   = clearing ? '0 : bus.wr_rgb;
            assign re      = is_back ? rb_req : bus.rd_req;
            assign raddr   = is_back ? wr_addr : rd_addr;

            ledpanel_fb_bank u_bank (
                .clk   (clk),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .re    (re),
                .raddr (raddr),
                .rdata (bank_rdata[b][k])
            );
        end
    end

    always_comb begin
        rd_mux      = '0;
        rd_mux.rgb1 = bank_rdata[rd_sel_q][0];
        rd_mux.rgb2 = bank_rdata[rd_sel_q][1];
    end

    // Bank read registers can be reused by later accesses, so idle cycles replay the held pair
    assign bus.rd_rgb1   = rd_valid_q ? rd_mux.rgb1 : rd_hold_q.rgb1;
    assign bus.rd_rgb2   = rd_valid_q ? rd_mux.rgb2 : rd_hold_q.rgb2;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.swap_done = swap_done_q;

`ifdef LEDPANEL_FB_READBACK_EN
    logic rb_valid_q, rb_sel_q, rb_bank_q, rb_zero_q;
    rgb_t rb_hold_q, rb_mux;

    assign rb_req = bus.rb_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_valid_q <= 1'b0;
            rb_sel_q   <= 1'b0;
            rb_bank_q  <= 1'b0;
            rb_zero_q  <= 1'b0;
            rb_hold_q  <= '0;
        end else begin
            rb_valid_q <= bus.rb_en;
            rb_sel_q   <= ~front_q;
            rb_bank_q  <= bus.wr_y[Y_W-1];
            rb_zero_q  <= clearing;
            if (rb_valid_q) rb_hold_q <= rb_mux;
        end
    end

    // A buffer under clear reads as blank regardless of how far the sweep has progressed
    assign rb_mux       = rb_zero_q ? '0 : bank_rdata[rb_sel_q][rb_bank_q];
    assign bus.rb_rgb   = rb_valid_q ? rb_mux : rb_hold_q;
    assign bus.rb_valid = rb_valid_q;
`else
    assign rb_req = 1'b0;
`endif
endmodule

// File: tb/tb_ledpanel_framebuf.sv
// Scoreboard bench for ledpanel_framebuf: a whole-frame array model predicts every scan read,
// wr_ready and swap_done; a negedge monitor pops and compares.
module tb_ledpanel_framebuf;
    import ledpanel_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ledpanel_framebuf_if bus();

    ledpanel_framebuf dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    rgb_t            m_mem [2][ROWS][COLS];
    rgb_t            saved [ROWS][COLS];
    logic            m_front     = 1'b0;
    logic            m_pending   = 1'b0;
    logic            m_swap_done = 1'b0;
    int              m_clr_left  = 0;
    rgb_t            m_last1     = '0;
    rgb_t            m_last2     = '0;
    logic [5:0]      exp_q [$];
    logic            mon_en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: one call per clock edge using the inputs presented to that edge
    task automatic model_step();
        logic ready, swp;
        int   fr, bk;
        ready = (m_clr_left == 0);
        fr    = m_front ? 1 : 0;
        bk    = 1 - fr;
        if (bus.rd_req)
            exp_q.push_back({m_mem[fr][int'(bus.rd_row)][int'(bus.rd_col)],
                             m_mem[fr][int'(bus.rd_row) + ROW_PAIRS][int'(bus.rd_col)]});
        if (bus.wr_en && ready)
            m_mem[bk][int'(bus.wr_y)][int'(bus.wr_x)] = bus.wr_rgb;
        swp = bus.frame_done && (m_pending || bus.swap_req) && ready;
        m_swap_done = swp;
        if (swp) begin
            m_front   = !m_front;
            m_pending = 1'b0;
        end else if (bus.swap_req) begin
            m_pending = 1'b1;
        end
        if (ready && bus.clear_req) begin
            m_clr_left = ROW_PAIRS * COLS;
            bk = m_front ? 0 : 1;
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++)
                    m_mem[bk][y][x] = '0;
        end else if (m_clr_left > 0) begin
            m_clr_left--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
        bus.wr_en      = 1'b0;
        bus.rd_req     = 1'b0;
        bus.swap_req   = 1'b0;
        bus.frame_done = 1'b0;
        bus.clear_req  = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [5:0] e;
        if (mon_en && reset) begin
            chk("wr_ready", 32'(bus.wr_ready), 32'(m_clr_left == 0));
            chk("swap_done", 32'(bus.swap_done), 32'(m_swap_done));
            chk("rd_valid", 32'(bus.rd_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e       = exp_q.pop_front();
                m_last1 = e[5:3];
                m_last2 = e[2:0];
            end
            chk("rd_rgb1", 32'(bus.rd_rgb1), 32'(m_last1));
            chk("rd_rgb2", 32'(bus.rd_rgb2), 32'(m_last2));
        end
    end

    initial begin
        int low, pulses;
        bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
        bus.clear_req = 1'b0; bus.swap_req = 1'b0; bus.frame_done = 1'b0;
        bus.rd_req = 1'b0; bus.rd_row = '0; bus.rd_col = '0;
        for (int b = 0; b < 2; b++)
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++)
                    m_mem[b][y][x] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_swap_done", 32'(bus.swap_done), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_rgb1", 32'(bus.rd_rgb1), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Clear back buffer (buffer 1); every write during the clear must vanish
        bus.clear_req = 1'b1;
        tick();
        low = 0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.wr_ready) low++;
            bus.wr_en  = (i < 256);
            bus.wr_x   = X_W'($urandom);
            bus.wr_y   = Y_W'($urandom);
            bus.wr_rgb = 3'b111;
            tick();
        end
        chk("clear_busy_cycles", 32'(low), 32'd256);

        // Swap and clear the other buffer so both are known blank
        bus.swap_req = 1'b1; bus.frame_done = 1'b1;
        tick();
        bus.clear_req = 1'b1;
        tick();
        repeat (260) tick();
        for (int i = 0; i < 32; i++) begin
            bus.rd_req = 1'b1;
            bus.rd_row = R_W'($urandom);
            bus.rd_col = X_W'($urandom);
            tick();
        end

        // Upper-bank pixel reaches rd_rgb1 after swap
        bus.wr_en = 1'b1; bus.wr_x = 5'd5; bus.wr_y = 4'd2; bus.wr_rgb = 3'b101;
        tick();
        bus.swap_req = 1'b1; bus.frame_done = 1'b1;
        tick();
        bus.rd_req = 1'b1; bus.rd_row = 3'd2; bus.rd_col = 5'd5;
        tick();
        @(negedge clk);
        chk("t1_rgb1", 32'(bus.rd_rgb1), 32'(3'b101));

        // Lower-bank pixel reaches rd_rgb2; upper half of that column stays blank
        bus.wr_en = 1'b1; bus.wr_x = 5'd31; bus.wr_y = 4'd10; bus.wr_rgb = 3'b011;
        tick();
        bus.swap_req = 1'b1; bus.frame_done = 1'b1;
        tick();
        bus.rd_req = 1'b1; bus.rd_row = 3'd2; bus.rd_col = 5'd31;
        tick();
        @(negedge clk);
        chk("t2_rgb2", 32'(bus.rd_rgb2), 32'(3'b011));
        chk("t2_rgb1", 32'(bus.rd_rgb1), 32'd0);

        // Pending swap waits indefinitely for frame_done
        bus.swap_req = 1'b1;
        tick();
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.swap_done) pulses++;
            bus.swap_req = (i % 100 == 7);
            tick();
        end
        chk("no_swap_without_frame", 32'(pulses), 32'd0);
        bus.frame_done = 1'b1;
        tick();
        chk("swap_done_pulse", 32'(bus.swap_done), 32'd1);
        tick();
        chk("swap_done_single", 32'(bus.swap_done), 32'd0);

        // frame_done during a clear must not swap; the pending request survives it
        bus.swap_req = 1'b1;
        tick();
        bus.clear_req = 1'b1;
        tick();
        repeat (50) tick();
        bus.frame_done = 1'b1;
        tick();
        chk("no_swap_in_clear", 32'(bus.swap_done), 32'd0);
        for (int i = 0; i < 300 && m_clr_left != 0; i++) tick();
        chk("clear_end_ready", 32'(bus.wr_ready), 32'd1);
        bus.frame_done = 1'b1;
        tick();
        chk("swap_after_clear", 32'(bus.swap_done), 32'd1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bus.wr_en      = ($urandom_range(1) == 1);
            bus.wr_x       = X_W'($urandom);
            bus.wr_y       = Y_W'($urandom);
            bus.wr_rgb     = RGB_W'($urandom);
            bus.rd_req     = ($urandom_range(1) == 1);
            bus.rd_row     = R_W'($urandom);
            bus.rd_col     = X_W'($urandom);
            bus.swap_req   = ($urandom_range(39) == 0);
            bus.frame_done = ($urandom_range(29) == 0);
            bus.clear_req  = ($urandom_range(499) == 0);
            tick();
        end

        // Reset in the middle of clearing buffer 0 while buffer 1 is front
        for (int i = 0; i < 300 && m_clr_left != 0; i++) tick();
        chk("idle_before_reset", 32'(bus.wr_ready), 32'd1);
        if (m_front == 1'b0) begin
            bus.swap_req = 1'b1; bus.frame_done = 1'b1;
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            bus.wr_en = 1'b1; bus.wr_rgb = 3'b111;
            bus.wr_x  = X_W'(c * 2);
            bus.wr_y  = Y_W'(4 + (c % 4) + ((c >= 8) ? 8 : 0));
            tick();
        end
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                saved[y][x] = m_mem[0][y][x];
        bus.clear_req = 1'b1;
        tick();
        repeat (98) tick();
        bus.rd_req = 1'b1; bus.rd_row = 3'd5; bus.rd_col = 5'd2;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("async_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("async_rd_rgb1", 32'(bus.rd_rgb1), 32'd0);
        chk("async_rd_rgb2", 32'(bus.rd_rgb2), 32'd0);
        chk("async_swap_done", 32'(bus.swap_done), 32'd0);
        exp_q.delete();
        m_front = 1'b0; m_pending = 1'b0; m_swap_done = 1'b0; m_clr_left = 0;
        m_last1 = '0; m_last2 = '0;
        for (int y = 4; y < 8; y++)
            for (int x = 0; x < COLS; x++) begin
                m_mem[0][y][x]             = saved[y][x];
                m_mem[0][y + ROW_PAIRS][x] = saved[y + ROW_PAIRS][x];
            end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Rows beyond the aborted sweep show buffer 0 is front again
        for (int i = 0; i < 24; i++) begin
            bus.rd_req = 1'b1;
            bus.rd_row = R_W'(4 + (i % 4));
            bus.rd_col = X_W'((i < 16) ? (i * 2) : $urandom);
            tick();
        end
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
